// File: rtl/l0_loader_pkg.sv
// l0_loader_pkg: shared types and constants for the L0 loader.
//   state_t    - loader FSM states
//   SKID_DEPTH - entries in the skid buffer (covers the 1-cycle SRAM read latency)
package l0_loader_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/l0_skid_buf.sv
// l0_skid_buf: 2-entry FIFO that absorbs SRAM read data ahead of L0.
//   clk, reset (async, active-low)
//   push/din  - write one word
//   pop       - drop the head word
//   dout      - registered head word
//   count     - occupancy, 0..2
module l0_skid_buf
    import l0_loader_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] data_q [SKID_DEPTH];
    logic         wr_q, rd_q;
    logic [1:0]   cnt_q;

    // Two entries, so each pointer is a single toggling bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_q] <= din;
                wr_q         <= !wr_q;
            end
            if (pop) rd_q <= !rd_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = data_q[rd_q];
    assign count = cnt_q;
endmodule

// File: rtl/l0_loader.sv
// l0_loader: fetches `length` vectors from the activation SRAM starting at
// `base_addr` and pushes them into the L0 FIFO bank in address order,
// honouring `l0_full` as backpressure.
//   clk, reset (async, active-low)
//   start, base_addr, length - job command, taken only in IDLE
//   busy, done               - status; done pulses one cycle at job end
//   mem_cen, mem_a, mem_q    - SRAM read port (1-cycle latency)
//   l0_full, l0_wr, l0_in    - L0 write port
// Optional: define L0_LOADER_STALL_CNT_EN to add stall_cnt[15:0], a saturating
// count of cycles where data was waiting but L0 was full.
module l0_loader
    import l0_loader_pkg::*;
#(
    parameter int row    = 8,
    parameter int bw     = 4,
    parameter int addr_w = 11,
    parameter int len_w  = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addr_w-1:0]   base_addr,
    input  logic [len_w-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic                mem_cen,
    output logic [addr_w-1:0]   mem_a,
    input  logic [row*bw-1:0]   mem_q,
    input  logic                l0_full,
    output logic                l0_wr,
    output logic [row*bw-1:0]   l0_in
`ifdef L0_LOADER_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);
    state_t            state_q, state_d;
    logic [addr_w-1:0] base_q;
    logic [len_w-1:0]  len_q, issued_q, issued_inc;
    logic              inflight_q;
    logic [1:0]        skid_cnt;
    logic [2:0]        occ;
    logic              accept, issue;

    assign accept     = (state_q == IDLE) && start;
    assign l0_wr      = (skid_cnt != 2'd0) && !l0_full;
    assign issued_inc = issued_q + len_w'(1);
    assign occ        = {1'b0, skid_cnt} + {2'b0, inflight_q};
    // Credit check: a read may go out only if, after this cycle's pop, the
    // words in the skid plus in flight still leave room for its data.
    assign issue      = (state_q == FETCH) && (occ < 3'(SKID_DEPTH) + {2'b0, l0_wr});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (length == '0) ? DONE : FETCH;
            FETCH:   if (issue && issued_inc == len_q) state_d = DRAIN;
            DRAIN:   if (occ == {2'b0, l0_wr}) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = state_q != IDLE;
        done    = state_q == DONE;
        mem_cen = !issue;
        mem_a   = issue ? base_q + addr_w'(issued_q) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (accept) begin
                base_q   <= base_addr;
                len_q    <= length;
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_inc;
            end
        end
    end

    l0_skid_buf #(.W(row*bw)) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_q),
        .pop   (l0_wr),
        .din   (mem_q),
        .dout  (l0_in),
        .count (skid_cnt)
    );

`ifdef L0_LOADER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_q <= '0;
        else if (accept)
            stall_q <= '0;
        else if (skid_cnt != 2'd0 && l0_full && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_l0_loader.sv
// tb_l0_loader: self-checking bench for l0_loader against a transaction-level
// model (expected address/data sequences, done timing, credit and write-guard rules).
module tb_l0_loader;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, l0_full = 1'b0;
    logic [10:0] base_addr = '0, length = '0, mem_a;
    logic [31:0] mem_q = '0, l0_in;
    logic        busy, done, mem_cen, l0_wr;
`ifdef L0_LOADER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    l0_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_cen   (mem_cen),
        .mem_a     (mem_a),
        .mem_q     (mem_q),
        .l0_full   (l0_full),
        .l0_wr     (l0_wr),
        .l0_in     (l0_in)
`ifdef L0_LOADER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] sram [2048];
    int          cyc = 0, t0 = 0, viol = 0, occ = 0, n_chk = 0, n_pass = 0;
    logic        mon_on = 1'b0;
    logic [10:0] rd_addr_q [$];
    int          rd_rel_q [$];
    logic [31:0] wr_data_q [$];
    int          wr_rel_q [$];
    int          done_q [$];

    always @(posedge clk) cyc++;

    // SRAM: data for a read issued this cycle appears next cycle; otherwise junk.
    always @(posedge clk) mem_q <= !mem_cen ? sram[mem_a] : $urandom();

    always @(negedge clk) begin
        if (mon_on) begin
            if (l0_wr && l0_full) viol++;
            if (occ > 2) viol++;
            if (!mem_cen) begin
                rd_addr_q.push_back(mem_a);
                rd_rel_q.push_back(cyc - t0);
            end
            if (l0_wr) begin
                wr_data_q.push_back(l0_in);
                wr_rel_q.push_back(cyc - t0);
            end
            if (done) done_q.push_back(cyc - t0);
            occ = occ + (!mem_cen ? 1 : 0) - (l0_wr ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic full_at(input int mode, input int r);
        return mode == 1 ? (r >= 3 && r <= 5) : mode == 2 ? ($urandom_range(0, 2) == 0) : 1'b0;
    endfunction

    task automatic score(input logic [10:0] b, input logic [10:0] n, input int mode);
        int exp_done;
        check("n_reads", rd_addr_q.size(), n);
        check("n_writes", wr_data_q.size(), n);
        for (int i = 0; i < rd_addr_q.size() && i < int'(n); i++)
            check("rd_addr", rd_addr_q[i], (int'(b) + i) % 2048);
        for (int i = 0; i < wr_data_q.size() && i < int'(n); i++)
            check("wr_data", wr_data_q[i], sram[(int'(b) + i) % 2048]);
        check("n_done", done_q.size(), 1);
        exp_done = (n == 0) ? 1 : (wr_rel_q.size() > 0 ? wr_rel_q[$] + 1 : -1);
        if (done_q.size() > 0) check("done_rel", done_q[0], exp_done);
        check("guard", viol, 0);
        if (mode == 0 && n != 0 && wr_rel_q.size() == int'(n) && rd_rel_q.size() == int'(n)) begin
            check("first_rd", rd_rel_q[0], 1);
            check("last_rd", rd_rel_q[$], n);
            check("first_wr", wr_rel_q[0], 3);
            check("last_wr", wr_rel_q[$], n + 2);
        end
        check("busy_end", busy, 0);
    endtask

    // Called at posedge+1; cycle 0 is the cycle in which start is driven.
    task automatic run_job(input logic [10:0] b, input logic [10:0] n, input int mode, input int spur);
        int lim;
        rd_addr_q.delete(); rd_rel_q.delete(); wr_data_q.delete(); wr_rel_q.delete(); done_q.delete();
        viol = 0;
        occ = 0;
        base_addr = b;
        length = n;
        start = 1'b1;
        t0 = cyc;
        l0_full = full_at(mode, 0);
        mon_on = 1'b1;
        lim = 4 * int'(n) + 40;
        for (int r = 1; r < lim; r++) begin
            @(posedge clk); #1;
            start = (r == spur);
            if (r == spur) begin
                base_addr = 11'h100;
                length = 11'd3;
            end
            l0_full = full_at(mode, r);
            if (done_q.size() > 0 && r > done_q[0] + 2) break;
        end
        mon_on = 1'b0;
        start = 1'b0;
        l0_full = 1'b0;
        score(b, n, mode);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) sram[i] = $urandom();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cen", mem_cen, 1);
        check("rst_addr", mem_a, 0);
        check("rst_wr", l0_wr, 0);
        check("rst_in", l0_in, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_job(11'h010, 11'd4, 0, -1);
        run_job(11'h055, 11'd0, 0, -1);
        run_job(11'h200, 11'd8, 1, -1);
`ifdef L0_LOADER_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 3);
`endif
        run_job(11'h7FE, 11'd4, 0, -1);
        run_job(11'h300, 11'd6, 0, 2);

        base_addr = 11'h040;
        length = 11'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_cen", mem_cen, 1);
        check("mid_addr", mem_a, 0);
        check("mid_wr", l0_wr, 0);
        check("mid_in", l0_in, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_job(11'h123, 11'd2, 0, -1);

        for (int j = 0; j < 15; j++) begin
            logic [10:0] b, n;
            b = 11'($urandom_range(0, 2047));
            n = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2)) : 11'($urandom_range(1, 24));
            run_job(b, n, 2 * int'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
